// File: rtl/jt12_slot_pkg.sv
// Shared widths, channel legality and scheduler state encoding for the FM slot sequencer.
package jt12_slot_pkg;

    localparam int OP_W = 2;
    localparam int CH_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } sched_state_e;

    // 6-channel mode leaves codes 3 and 7 unused; 3-channel mode uses 0..2 only.
    function automatic logic ch_legal(input int num_ch, input logic [CH_W-1:0] ch);
        if (num_ch == 3) begin
            return ch < 3'd3;
        end
        return (ch != 3'd3) && (ch != 3'd7);
    endfunction

    function automatic int frame_len(input int num_ch);
        return 4 * num_ch;
    endfunction

endpackage

// File: rtl/jt12_slot_cnt.sv
// Slot counter: walks {op, ch} over the legal channel codes, with frame sync and zero flag.
module jt12_slot_cnt
    import jt12_slot_pkg::*;
#(
    parameter int NUM_CH = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clk_en,
    input  logic            sync,
    output logic [OP_W-1:0] cur_op,
    output logic [CH_W-1:0] cur_ch,
    output logic            zero
);

    localparam logic [CH_W-1:0] LAST_CH = (NUM_CH == 3) ? 3'd2 : 3'd6;

    logic [OP_W-1:0] op_q, op_d;
    logic [CH_W-1:0] ch_q, ch_d;

    always_comb begin
        op_d = op_q;
        ch_d = ch_q;
        if (sync) begin
            op_d = '0;
            ch_d = '0;
        end else if (ch_q == LAST_CH) begin
            ch_d = '0;
            op_d = op_q + 1'b1;
        end else if (ch_q == 3'd2) begin
            // only reachable in 6-channel mode: hop over the unused code 3
            ch_d = 3'd4;
        end else begin
            ch_d = ch_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
            ch_q <= '0;
        end else if (clk_en) begin
            op_q <= op_d;
            ch_q <= ch_d;
        end
    end

    assign cur_op = op_q;
    assign cur_ch = ch_q;
    assign zero   = (op_q == '0) && (ch_q == '0);

endmodule

// File: rtl/jt12_slot_sched.sv
// Slot sequencer plus single-entry register-update scheduler; releases a held write as a
// one-slot strobe when its target slot passes.
module jt12_slot_sched
    import jt12_slot_pkg::*;
#(
    parameter int NUM_CH = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clk_en,
    input  logic            sync,
    output logic [OP_W-1:0] cur_op,
    output logic [CH_W-1:0] cur_ch,
    output logic            zero,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [OP_W-1:0] wr_op,
    input  logic [CH_W-1:0] wr_ch,
    input  logic            wr_all,
    input  logic [3:0]      wr_reg,
    input  logic [7:0]      wr_data,
    output logic            up_en,
    output logic [3:0]      up_reg,
    output logic [7:0]      up_data,
    output logic            wr_err
);

    sched_state_e    state_q;
    logic [3:0]      mask_q;
    logic [CH_W-1:0] ch_q;
    logic [3:0]      reg_q;
    logic [7:0]      data_q;
    logic            err_q;

    logic [3:0] op_bit;
    logic [3:0] mask_left;
    logic       accept;
    logic       legal;
    logic       hit;

    jt12_slot_cnt #(
        .NUM_CH (NUM_CH)
    ) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .sync   (sync),
        .cur_op (cur_op),
        .cur_ch (cur_ch),
        .zero   (zero)
    );

    assign op_bit    = 4'b0001 << cur_op;
    assign mask_left = mask_q & ~op_bit;
    assign accept    = wr_valid && (state_q == IDLE);
    assign legal     = ch_legal(NUM_CH, wr_ch);
    // Matching only begins the cycle after accept because the FSM is still IDLE in the accept cycle.
    assign hit       = (state_q == WAIT) && clk_en && (cur_ch == ch_q) && ((mask_q & op_bit) != 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mask_q  <= '0;
            ch_q    <= '0;
            reg_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept && !legal;
            case (state_q)
                IDLE: begin
                    if (accept && legal) begin
                        ch_q    <= wr_ch;
                        reg_q   <= wr_reg;
                        data_q  <= wr_data;
                        mask_q  <= wr_all ? 4'b1111 : (4'b0001 << wr_op);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (hit) begin
                        mask_q <= mask_left;
                        if (mask_left == 4'd0) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_ready = (state_q == IDLE);
    assign up_en    = hit;
    assign up_reg   = reg_q;
    assign up_data  = data_q;
    assign wr_err   = err_q;

endmodule

// File: tb/tb_jt12_slot_sched.sv
// Scoreboard bench: 6-channel and 3-channel instances share stimulus; a slot-index model
// predicts every output per cycle and a negedge monitor checks the DUTs against it.
module tb_jt12_slot_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_en = 1'b0;
    logic       sync = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_all = 1'b0;
    logic [1:0] wr_op = '0;
    logic [2:0] wr_ch = '0;
    logic [3:0] wr_reg = '0;
    logic [7:0] wr_data = '0;

    logic [1:0] cur_op [2];
    logic [2:0] cur_ch [2];
    logic       zero [2];
    logic       wr_ready [2];
    logic       up_en [2];
    logic       wr_err [2];
    logic [3:0] up_reg [2];
    logic [7:0] up_data [2];

    always #5 clk = ~clk;

    jt12_slot_sched #(.NUM_CH(6)) dut6 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .sync(sync),
        .cur_op(cur_op[0]), .cur_ch(cur_ch[0]), .zero(zero[0]),
        .wr_valid(wr_valid), .wr_ready(wr_ready[0]), .wr_op(wr_op), .wr_ch(wr_ch),
        .wr_all(wr_all), .wr_reg(wr_reg), .wr_data(wr_data),
        .up_en(up_en[0]), .up_reg(up_reg[0]), .up_data(up_data[0]), .wr_err(wr_err[0])
    );

    jt12_slot_sched #(.NUM_CH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .sync(sync),
        .cur_op(cur_op[1]), .cur_ch(cur_ch[1]), .zero(zero[1]),
        .wr_valid(wr_valid), .wr_ready(wr_ready[1]), .wr_op(wr_op), .wr_ch(wr_ch),
        .wr_all(wr_all), .wr_reg(wr_reg), .wr_data(wr_data),
        .up_en(up_en[1]), .up_reg(up_reg[1]), .up_data(up_data[1]), .wr_err(wr_err[1])
    );

    typedef struct {
        int cyc;
        int op;
        int ch;
        bit zero;
        bit ready;
        bit up;
        bit err;
        int ureg;
        int udata;
    } exp_t;

    exp_t q6[$];
    exp_t q3[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    // Reference state: slot index within the frame plus the pending write.
    int       m_s [2];
    bit       m_wait [2];
    bit [3:0] m_mask [2];
    int       m_ch [2];
    int       m_reg [2];
    int       m_data [2];
    bit       m_err [2];
    int       up_seen [2];

    function automatic int nch(input int d);
        return (d == 0) ? 6 : 3;
    endfunction

    function automatic int code_of(input int d, input int k);
        if (d == 0 && k >= 3) return k + 1;
        return k;
    endfunction

    function automatic bit legal(input int d, input int c);
        if (d == 0) return (c != 3) && (c != 7);
        return c < 3;
    endfunction

    task automatic chk(input int d, input string nm, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL ch%0d %s cyc=%0d got=%0d want=%0d", nch(d), nm, cyc, act, want);
        end
    endtask

    task automatic mreset();
        for (int d = 0; d < 2; d++) begin
            m_s[d] = 0; m_wait[d] = 0; m_mask[d] = '0; m_ch[d] = 0;
            m_reg[d] = 0; m_data[d] = 0; m_err[d] = 0;
        end
    endtask

    task automatic cycle(input bit en, input bit syn, input bit wv, input int wop,
                         input int wch, input bit wall, input int wreg, input int wdata);
        clk_en = en; sync = syn; wr_valid = wv; wr_all = wall;
        wr_op = 2'(wop); wr_ch = 3'(wch); wr_reg = 4'(wreg); wr_data = 8'(wdata);
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            int n, op, ch;
            bit nerr;
            n = nch(d);
            op = m_s[d] / n;
            ch = code_of(d, m_s[d] % n);
            e.cyc = cyc; e.op = op; e.ch = ch; e.zero = (m_s[d] == 0);
            e.ready = !m_wait[d]; e.err = m_err[d]; e.ureg = m_reg[d]; e.udata = m_data[d];
            e.up = 0;
            nerr = 0;
            if (m_wait[d]) begin
                if (en && ch == m_ch[d] && m_mask[d][op]) begin
                    e.up = 1;
                    m_mask[d][op] = 1'b0;
                    if (m_mask[d] == 0) m_wait[d] = 0;
                end
            end else if (wv) begin
                if (legal(d, wch)) begin
                    m_wait[d] = 1; m_ch[d] = wch; m_reg[d] = wreg; m_data[d] = wdata;
                    m_mask[d] = wall ? 4'b1111 : (4'b0001 << wop);
                end else begin
                    nerr = 1;
                end
            end
            m_err[d] = nerr;
            if (en) m_s[d] = syn ? 0 : (m_s[d] + 1) % (4 * n);
            if (d == 0) q6.push_back(e); else q3.push_back(e);
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((m_wait[0] || m_wait[1]) && n < 100) begin
            cycle(1, 0, 0, 0, 0, 0, 0, 0);
            n++;
        end
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic goto_slot6(input int s);
        int n = 0;
        while (m_s[0] != s && n < 30) begin
            cycle(1, 0, 0, 0, 0, 0, 0, 0);
            n++;
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            bit have;
            have = 0;
            if (d == 0 && q6.size() > 0 && q6[0].cyc == cyc) begin e = q6.pop_front(); have = 1; end
            if (d == 1 && q3.size() > 0 && q3[0].cyc == cyc) begin e = q3.pop_front(); have = 1; end
            if (have) begin
                chk(d, "cur_op", int'(cur_op[d]), e.op);
                chk(d, "cur_ch", int'(cur_ch[d]), e.ch);
                chk(d, "zero", int'(zero[d]), int'(e.zero));
                chk(d, "wr_ready", int'(wr_ready[d]), int'(e.ready));
                chk(d, "wr_err", int'(wr_err[d]), int'(e.err));
                chk(d, "up_en", int'(up_en[d]), int'(e.up));
                chk(d, "up_reg", int'(up_reg[d]), e.ureg);
                chk(d, "up_data", int'(up_data[d]), e.udata);
                if (up_en[d] === 1'b1) up_seen[d]++;
            end
        end
    end

    initial begin
        int pulses_before;
        mreset();
        up_seen[0] = 0; up_seen[1] = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // full frames of slot walking in both channel modes
        run(24);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);

        // single write op2/ch5 issued at frame start
        goto_slot6(0);
        cycle(1, 0, 1, 2, 5, 0, 4'h3, 8'hA5);
        drain();

        // wr_all on ch4 accepted at op1/ch5
        goto_slot6(10);
        cycle(1, 0, 1, 0, 4, 1, 4'h7, 8'h3C);
        drain();

        // illegal channel 3, then two frames with no update expected
        pulses_before = up_seen[0];
        cycle(1, 0, 1, 1, 3, 0, 4'h9, 8'h11);
        run(48);
        chk(0, "no_up_after_illegal", up_seen[0] - pulses_before, 0);

        // pending op3/ch1 survives a sync issued at op0/ch2
        goto_slot6(0);
        cycle(1, 0, 1, 3, 1, 0, 4'h2, 8'h5A);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0, 0);
        drain();

        // reset in the middle of WAIT drops the pending write
        cycle(1, 0, 1, 1, 6, 0, 4'hE, 8'hC3);
        run(3);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        mreset();
        pulses_before = up_seen[0];
        run(48);
        chk(0, "no_up_after_reset", up_seen[0] - pulses_before, 0);

        // randomized traffic with gated enables and occasional sync
        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
                  $urandom_range(0, 2) == 0, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
        end
        drain();
        run(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
